// File: rtl/gpio_apb_sequencer.sv
// APB3 master that loads a GPIO peripheral's configuration registers after a start pulse,
// then services its interrupt (read status, write-1-to-clear) and software write requests.
module gpio_apb_sequencer #(
    parameter int GPIO_PINS  = 32,
    parameter int PADDR_SIZE = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                    pclk,
    input  logic                    prstn,
    input  logic                    start,
    input  logic [GPIO_PINS-1:0]    cfg_mode,
    input  logic [GPIO_PINS-1:0]    cfg_dir,
    input  logic [GPIO_PINS-1:0]    cfg_out,
    input  logic [GPIO_PINS-1:0]    cfg_trig_type,
    input  logic [GPIO_PINS-1:0]    cfg_trig_lvl0,
    input  logic [GPIO_PINS-1:0]    cfg_trig_lvl1,
    input  logic [GPIO_PINS-1:0]    cfg_irq_ena,
    input  logic                    sw_req,
    input  logic [PADDR_SIZE-1:0]   sw_addr,
    input  logic [GPIO_PINS-1:0]    sw_wdata,
    output logic                    sw_ack,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [PADDR_SIZE-1:0]   paddr,
    output logic [GPIO_PINS-1:0]    pwrdata,
    output logic [GPIO_PINS/8-1:0]  pstrb,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic [GPIO_PINS-1:0]    prddata,
    input  logic                    irq_o,
    output logic                    cfg_done,
    output logic                    err,
    output logic [GPIO_PINS-1:0]    irq_status,
    output logic                    irq_valid
);

    localparam int STRB_W = GPIO_PINS / 8;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [PADDR_SIZE-1:0] A_MODE      = PADDR_SIZE'(0);
    localparam logic [PADDR_SIZE-1:0] A_DIRECTION = PADDR_SIZE'(1);
    localparam logic [PADDR_SIZE-1:0] A_OUTPUT    = PADDR_SIZE'(2);
    localparam logic [PADDR_SIZE-1:0] A_TR_TYPE   = PADDR_SIZE'(4);
    localparam logic [PADDR_SIZE-1:0] A_TR_LVL0   = PADDR_SIZE'(5);
    localparam logic [PADDR_SIZE-1:0] A_TR_LVL1   = PADDR_SIZE'(6);
    localparam logic [PADDR_SIZE-1:0] A_TR_STATUS = PADDR_SIZE'(7);
    localparam logic [PADDR_SIZE-1:0] A_IRQ_ENA   = PADDR_SIZE'(8);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_IRQ_RD  = 3'd4;
    localparam logic [2:0] S_IRQ_CLR = 3'd5;

    logic [2:0]            r_state,      w_state;
    logic [2:0]            r_idx,        w_idx;
    logic                  r_is_sw,      w_is_sw;
    logic [TMO_W-1:0]      r_tmo_cnt,    w_tmo_cnt;
    logic                  r_psel,       w_psel;
    logic                  r_penable,    w_penable;
    logic                  r_pwrite,     w_pwrite;
    logic [PADDR_SIZE-1:0] r_paddr,      w_paddr;
    logic [GPIO_PINS-1:0]  r_pwrdata,    w_pwrdata;
    logic [STRB_W-1:0]     r_pstrb,      w_pstrb;
    logic                  r_sw_ack,     w_sw_ack;
    logic                  r_cfg_done,   w_cfg_done;
    logic                  r_err,        w_err;
    logic [GPIO_PINS-1:0]  r_irq_status, w_irq_status;
    logic                  r_irq_valid,  w_irq_valid;

    logic [2:0]            w_next_idx;
    logic [PADDR_SIZE-1:0] w_cfg_addr;
    logic [GPIO_PINS-1:0]  w_cfg_data;
    logic                  w_tmo_hit;

    assign w_next_idx = (r_state == S_IDLE) ? 3'd0 : (r_idx + 3'd1);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Address/data of the configuration write selected by the next index.
    always_comb begin
        w_cfg_addr = A_MODE;
        w_cfg_data = cfg_mode;
        case (w_next_idx)
            3'd0:    begin w_cfg_addr = A_MODE;      w_cfg_data = cfg_mode;      end
            3'd1:    begin w_cfg_addr = A_DIRECTION; w_cfg_data = cfg_dir;       end
            3'd2:    begin w_cfg_addr = A_OUTPUT;    w_cfg_data = cfg_out;       end
            3'd3:    begin w_cfg_addr = A_TR_TYPE;   w_cfg_data = cfg_trig_type; end
            3'd4:    begin w_cfg_addr = A_TR_LVL0;   w_cfg_data = cfg_trig_lvl0; end
            3'd5:    begin w_cfg_addr = A_TR_LVL1;   w_cfg_data = cfg_trig_lvl1; end
            3'd6:    begin w_cfg_addr = A_IRQ_ENA;   w_cfg_data = cfg_irq_ena;   end
            default: begin w_cfg_addr = A_MODE;      w_cfg_data = cfg_mode;      end
        endcase
    end

    // Sequencer next-state and next-output logic; all APB outputs are registered.
    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_is_sw      = r_is_sw;
        w_tmo_cnt    = r_tmo_cnt;
        w_psel       = r_psel;
        w_penable    = r_penable;
        w_pwrite     = r_pwrite;
        w_paddr      = r_paddr;
        w_pwrdata    = r_pwrdata;
        w_pstrb      = r_pstrb;
        w_sw_ack     = 1'b0;
        w_cfg_done   = r_cfg_done;
        w_err        = r_err;
        w_irq_status = r_irq_status;
        w_irq_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                if (start) begin
                    w_state   = S_SETUP;
                    w_idx     = 3'd0;
                    w_is_sw   = 1'b0;
                    w_psel    = 1'b1;
                    w_pwrite  = 1'b1;
                    w_paddr   = w_cfg_addr;
                    w_pwrdata = w_cfg_data;
                    w_pstrb   = '1;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SETUP: begin
                w_state   = S_ACCESS;
                w_penable = 1'b1;
                w_tmo_cnt = '0;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_err = r_err | pslverr;
                    if (r_is_sw) begin
                        w_state   = S_RUN;
                        w_psel    = 1'b0;
                        w_penable = 1'b0;
                        w_sw_ack  = 1'b1;
                    end else if (r_idx == 3'd6) begin
                        w_state    = S_RUN;
                        w_psel     = 1'b0;
                        w_penable  = 1'b0;
                        w_cfg_done = 1'b1;
                    end else begin
                        w_state   = S_SETUP;
                        w_idx     = w_next_idx;
                        w_penable = 1'b0;
                        w_paddr   = w_cfg_addr;
                        w_pwrdata = w_cfg_data;
                    end
                end else if (w_tmo_hit) begin
                    w_state   = S_IDLE;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_err     = 1'b1;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
                end
            end
            S_RUN: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                // r_sw_ack masks the requester's still-high sw_req in the ack cycle.
                if (irq_o) begin
                    w_state  = S_IRQ_RD;
                    w_psel   = 1'b1;
                    w_pwrite = 1'b0;
                    w_paddr  = A_TR_STATUS;
                    w_pstrb  = '0;
                end else if (sw_req && !r_sw_ack) begin
                    w_state   = S_SETUP;
                    w_is_sw   = 1'b1;
                    w_psel    = 1'b1;
                    w_pwrite  = 1'b1;
                    w_paddr   = sw_addr;
                    w_pwrdata = sw_wdata;
                    w_pstrb   = '1;
                end else begin
                    w_state = S_RUN;
                end
            end
            S_IRQ_RD: begin
                if (!r_penable) begin
                    w_penable = 1'b1;
                    w_tmo_cnt = '0;
                end else if (pready) begin
                    w_err        = r_err | pslverr;
                    w_irq_status = prddata;
                    w_irq_valid  = 1'b1;
                    w_state      = S_IRQ_CLR;
                    w_penable    = 1'b0;
                    w_pwrite     = 1'b1;
                    w_pwrdata    = prddata;
                    w_pstrb      = '1;
                end else if (w_tmo_hit) begin
                    w_state   = S_IDLE;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_err     = 1'b1;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
                end
            end
            S_IRQ_CLR: begin
                if (!r_penable) begin
                    w_penable = 1'b1;
                    w_tmo_cnt = '0;
                end else if (pready) begin
                    w_err     = r_err | pslverr;
                    w_state   = S_RUN;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                end else if (w_tmo_hit) begin
                    w_state   = S_IDLE;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                    w_err     = 1'b1;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_psel    = 1'b0;
                w_penable = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_state      <= S_IDLE;
            r_idx        <= 3'd0;
            r_is_sw      <= 1'b0;
            r_tmo_cnt    <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwrdata    <= '0;
            r_pstrb      <= '0;
            r_sw_ack     <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_err        <= 1'b0;
            r_irq_status <= '0;
            r_irq_valid  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_is_sw      <= w_is_sw;
            r_tmo_cnt    <= w_tmo_cnt;
            r_psel       <= w_psel;
            r_penable    <= w_penable;
            r_pwrite     <= w_pwrite;
            r_paddr      <= w_paddr;
            r_pwrdata    <= w_pwrdata;
            r_pstrb      <= w_pstrb;
            r_sw_ack     <= w_sw_ack;
            r_cfg_done   <= w_cfg_done;
            r_err        <= w_err;
            r_irq_status <= w_irq_status;
            r_irq_valid  <= w_irq_valid;
        end
    end

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwrdata    = r_pwrdata;
    assign pstrb      = r_pstrb;
    assign sw_ack     = r_sw_ack;
    assign cfg_done   = r_cfg_done;
    assign err        = r_err;
    assign irq_status = r_irq_status;
    assign irq_valid  = r_irq_valid;

endmodule

// File: tb/tb_gpio_apb_sequencer.sv
// Directed bench for gpio_apb_sequencer: a small APB slave model with stall/hang/slverr
// knobs plus a transfer recorder; each scenario task checks its own expectations.
module tb_gpio_apb_sequencer;

    logic        pclk;
    logic        prstn;
    logic        start;
    logic [31:0] cfg_mode, cfg_dir, cfg_out, cfg_trig_type, cfg_trig_lvl0, cfg_trig_lvl1, cfg_irq_ena;
    logic        sw_req;
    logic [3:0]  sw_addr;
    logic [31:0] sw_wdata;
    logic        sw_ack;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwrdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prddata;
    logic        irq_o;
    logic        cfg_done, err, irq_valid;
    logic [31:0] irq_status;

    // slave model knobs
    logic        hang;
    logic        stall_en;
    logic [3:0]  stall_addr;
    int          stall_cycles;
    logic        slverr_en;
    logic [3:0]  slverr_addr;
    int          acc_cnt = 0;

    // transfer recorder
    logic [3:0]  mon_addr [0:63];
    logic [31:0] mon_data [0:63];
    logic        mon_wr   [0:63];
    logic [3:0]  mon_strb [0:63];
    int          mon_acc  [0:63];
    int          mon_n = 0;
    logic        stable_bad = 1'b0;
    logic [3:0]  su_addr;
    logic [31:0] su_data;
    logic        su_wr;

    int errors = 0;
    int checks = 0;

    gpio_apb_sequencer dut (
        .pclk(pclk), .prstn(prstn), .start(start),
        .cfg_mode(cfg_mode), .cfg_dir(cfg_dir), .cfg_out(cfg_out),
        .cfg_trig_type(cfg_trig_type), .cfg_trig_lvl0(cfg_trig_lvl0),
        .cfg_trig_lvl1(cfg_trig_lvl1), .cfg_irq_ena(cfg_irq_ena),
        .sw_req(sw_req), .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_ack(sw_ack),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwrdata(pwrdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
        .prddata(prddata), .irq_o(irq_o), .cfg_done(cfg_done), .err(err),
        .irq_status(irq_status), .irq_valid(irq_valid)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    assign pready  = !hang && !(stall_en && psel && penable && (paddr == stall_addr) && (acc_cnt < stall_cycles));
    assign pslverr = slverr_en && psel && penable && (paddr == slverr_addr);

    always @(posedge pclk) begin
        if (psel && !penable) begin
            su_addr <= paddr;
            su_data <= pwrdata;
            su_wr   <= pwrite;
        end
        if (psel && penable) begin
            if (paddr !== su_addr || pwrdata !== su_data || pwrite !== su_wr) stable_bad <= 1'b1;
            if (pready && mon_n < 64) begin
                mon_addr[mon_n] <= paddr;
                mon_data[mon_n] <= pwrdata;
                mon_wr[mon_n]   <= pwrite;
                mon_strb[mon_n] <= pstrb;
                mon_acc[mon_n]  <= acc_cnt + 1;
                mon_n           <= mon_n + 1;
            end
        end
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cfg_done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_reset();
        prstn = 1'b0; start = 1'b0; sw_req = 1'b0; irq_o = 1'b0;
        hang = 1'b0; stall_en = 1'b0; slverr_en = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        prstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({psel, penable, pwrite, pstrb, sw_ack, cfg_done, err, irq_valid} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {psel, penable, pwrite, pstrb, sw_ack, cfg_done, err, irq_valid});
        end
        checks++;
        if (paddr !== 4'd0 || pwrdata !== 32'd0 || irq_status !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got paddr=%h pwrdata=%h irq_status=%h expected 0", paddr, pwrdata, irq_status);
        end
        @(negedge pclk);
        prstn = 1'b1;
        tick();
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got psel=%b expected 0", psel);
        end
    endtask

    task automatic test_cfg_sequence();
        int cyc;
        int base;
        int base2;
        logic [3:0]  exp_a [0:6];
        logic [31:0] exp_d [0:6];
        exp_a[0] = 4'd0; exp_d[0] = 32'h1111_1111;
        exp_a[1] = 4'd1; exp_d[1] = 32'hFFFF_FFFF;
        exp_a[2] = 4'd2; exp_d[2] = 32'h0000_0088;
        exp_a[3] = 4'd4; exp_d[3] = 32'h0000_F00F;
        exp_a[4] = 4'd5; exp_d[4] = 32'h0000_00AA;
        exp_a[5] = 4'd6; exp_d[5] = 32'h0000_5500;
        exp_a[6] = 4'd8; exp_d[6] = 32'h0000_C3C3;
        base = mon_n;
        pulse_start();
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 4'd0) begin
            errors++;
            $display("FAIL cfg_first_setup: got psel=%b penable=%b paddr=%h expected 1 0 0", psel, penable, paddr);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 14) begin
            errors++;
            $display("FAIL cfg_latency: got %0d cycles expected 14", cyc);
        end
        checks++;
        if (mon_n - base !== 7) begin
            errors++;
            $display("FAIL cfg_count: got %0d transfers expected 7", mon_n - base);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (mon_addr[base+i] !== exp_a[i] || mon_data[base+i] !== exp_d[i] ||
                mon_wr[base+i] !== 1'b1 || mon_strb[base+i] !== 4'hF) begin
                errors++;
                $display("FAIL cfg_write%0d: got a=%h d=%h w=%b s=%h expected a=%h d=%h w=1 s=f",
                         i, mon_addr[base+i], mon_data[base+i], mon_wr[base+i], mon_strb[base+i], exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (err !== 1'b0 || psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL cfg_run_state: got err=%b psel=%b penable=%b expected 0 0 0", err, psel, penable);
        end
        base2 = mon_n;
        pulse_start();
        repeat (5) tick();
        checks++;
        if (mon_n !== base2 || psel !== 1'b0 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_in_run: got %0d new transfers psel=%b cfg_done=%b expected 0 0 1",
                     mon_n - base2, psel, cfg_done);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        int base;
        do_reset();
        stall_en = 1'b1; stall_addr = 4'd1; stall_cycles = 2;
        base = mon_n;
        pulse_start();
        wait_done(cyc);
        stall_en = 1'b0;
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL wait_latency: got %0d cycles expected 16", cyc);
        end
        checks++;
        if (mon_addr[base+1] !== 4'd1 || mon_acc[base+1] !== 3 || mon_acc[base] !== 1) begin
            errors++;
            $display("FAIL wait_access_len: got addr=%h acc=%0d (mode acc=%0d) expected addr=1 acc=3 (1)",
                     mon_addr[base+1], mon_acc[base+1], mon_acc[base]);
        end
        checks++;
        if (stable_bad !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wait_stable: got unstable=%b err=%b expected 0 0", stable_bad, err);
        end
    endtask

    task automatic test_irq();
        int cyc;
        int base;
        base = mon_n;
        prddata = 32'h0000_0010;
        irq_o = 1'b1;
        cyc = 0;
        while (irq_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        irq_o = 1'b0;
        checks++;
        if (irq_valid !== 1'b1 || irq_status !== 32'h0000_0010 || cyc !== 3) begin
            errors++;
            $display("FAIL irq_status: got valid=%b status=%h after %0d cycles expected 1 00000010 3",
                     irq_valid, irq_status, cyc);
        end
        tick();
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL irq_valid_pulse: got %b expected 0", irq_valid);
        end
        cyc = 0;
        while (psel === 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (mon_n - base !== 2 || mon_addr[base] !== 4'd7 || mon_wr[base] !== 1'b0 || mon_strb[base] !== 4'h0) begin
            errors++;
            $display("FAIL irq_read: got n=%0d a=%h w=%b s=%h expected n=2 a=7 w=0 s=0",
                     mon_n - base, mon_addr[base], mon_wr[base], mon_strb[base]);
        end
        checks++;
        if (mon_addr[base+1] !== 4'd7 || mon_wr[base+1] !== 1'b1 || mon_data[base+1] !== 32'h0000_0010 ||
            mon_strb[base+1] !== 4'hF) begin
            errors++;
            $display("FAIL irq_clear: got a=%h w=%b d=%h s=%h expected a=7 w=1 d=00000010 s=f",
                     mon_addr[base+1], mon_wr[base+1], mon_data[base+1], mon_strb[base+1]);
        end
    endtask

    task automatic test_priority();
        int cyc;
        int base;
        base = mon_n;
        prddata  = 32'h0000_0010;
        sw_addr  = 4'd2;
        sw_wdata = 32'h0000_00FF;
        sw_req   = 1'b1;
        irq_o    = 1'b1;
        cyc = 0;
        while (irq_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        irq_o = 1'b0;
        checks++;
        if (irq_valid !== 1'b1 || mon_n - base !== 1 || mon_addr[base] !== 4'd7) begin
            errors++;
            $display("FAIL prio_irq_first: got valid=%b n=%0d a=%h expected 1 1 7", irq_valid, mon_n - base, mon_addr[base]);
        end
        cyc = 0;
        while (sw_ack !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++;
        if (sw_ack !== 1'b1) begin
            errors++;
            $display("FAIL prio_sw_ack: got %b expected 1", sw_ack);
        end
        sw_req = 1'b0;
        tick();
        checks++;
        if (sw_ack !== 1'b0) begin
            errors++;
            $display("FAIL sw_ack_pulse: got %b expected 0", sw_ack);
        end
        repeat (3) tick();
        checks++;
        if (mon_n - base !== 3 || mon_addr[base+1] !== 4'd7 || mon_addr[base+2] !== 4'd2 ||
            mon_data[base+2] !== 32'h0000_00FF || mon_wr[base+2] !== 1'b1) begin
            errors++;
            $display("FAIL prio_order: got n=%0d a1=%h a2=%h d2=%h w2=%b expected 3 7 2 000000ff 1",
                     mon_n - base, mon_addr[base+1], mon_addr[base+2], mon_data[base+2], mon_wr[base+2]);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int n_acc;
        int base;
        do_reset();
        hang = 1'b1;
        base = mon_n;
        pulse_start();
        cyc = 0;
        n_acc = 0;
        while (psel === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (penable === 1'b1) n_acc++;
        end
        checks++;
        if (n_acc !== 15 || psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: got %0d access cycles psel=%b penable=%b expected 15 0 0", n_acc, psel, penable);
        end
        checks++;
        if (err !== 1'b1 || cfg_done !== 1'b0 || mon_n !== base) begin
            errors++;
            $display("FAIL timeout_err: got err=%b cfg_done=%b n=%0d expected 1 0 0", err, cfg_done, mon_n - base);
        end
        hang = 1'b0;
        repeat (4) tick();
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got psel=%b expected 0", psel);
        end
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc !== 14 || mon_addr[base] !== 4'd0) begin
            errors++;
            $display("FAIL timeout_restart: got %0d cycles first a=%h expected 14 0", cyc, mon_addr[base]);
        end
    endtask

    task automatic test_slverr();
        int cyc;
        int base;
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL slverr_pre: got err=%b expected 0", err);
        end
        slverr_en = 1'b1;
        slverr_addr = 4'd0;
        base = mon_n;
        pulse_start();
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || psel !== 1'b1 || paddr !== 4'd1) begin
            errors++;
            $display("FAIL slverr_mode: got err=%b psel=%b paddr=%h expected 1 1 1", err, psel, paddr);
        end
        wait_done(cyc);
        slverr_en = 1'b0;
        checks++;
        if (cyc !== 12 || mon_n - base !== 7 || err !== 1'b1) begin
            errors++;
            $display("FAIL slverr_complete: got cyc=%0d n=%0d err=%b expected 12 7 1", cyc, mon_n - base, err);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int base;
        int sent;
        logic seen;
        do_reset();
        base = mon_n;
        pulse_start();
        cyc = 0;
        while (!(psel === 1'b1 && penable === 1'b1 && paddr === 4'd2) && cyc < 20) begin
            tick();
            cyc++;
        end
        #2;
        prstn = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, pstrb, sw_ack, cfg_done, err, irq_valid} !== 11'd0 ||
            paddr !== 4'd0 || pwrdata !== 32'd0 || irq_status !== 32'd0) begin
            errors++;
            $display("FAIL midreset_async: got ctrl=%b paddr=%h pwrdata=%h irq_status=%h expected 0",
                     {psel, penable, pwrite, pstrb, sw_ack, cfg_done, err, irq_valid}, paddr, pwrdata, irq_status);
        end
        @(negedge pclk);
        prstn = 1'b1;
        tick();
        sent = mon_n;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (psel !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || mon_n !== sent || sent - base !== 2) begin
            errors++;
            $display("FAIL midreset_quiet: got psel_seen=%b new=%0d before=%0d expected 0 0 2", seen, mon_n - sent, sent - base);
        end
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc !== 14 || mon_addr[sent] !== 4'd0 || mon_n - sent !== 7) begin
            errors++;
            $display("FAIL midreset_restart: got cyc=%0d a=%h n=%0d expected 14 0 7", cyc, mon_addr[sent], mon_n - sent);
        end
    endtask

    initial begin
        prstn = 1'b0; start = 1'b0; sw_req = 1'b0; irq_o = 1'b0;
        sw_addr = 4'd0; sw_wdata = 32'd0; prddata = 32'd0;
        hang = 1'b0; stall_en = 1'b0; stall_addr = 4'd0; stall_cycles = 0;
        slverr_en = 1'b0; slverr_addr = 4'd0;
        cfg_mode      = 32'h1111_1111;
        cfg_dir       = 32'hFFFF_FFFF;
        cfg_out       = 32'h0000_0088;
        cfg_trig_type = 32'h0000_F00F;
        cfg_trig_lvl0 = 32'h0000_00AA;
        cfg_trig_lvl1 = 32'h0000_5500;
        cfg_irq_ena   = 32'h0000_C3C3;
        test_reset();
        test_cfg_sequence();
        test_wait_states();
        test_irq();
        test_priority();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_apb_sequencer.md
GPIO_APB_SEQUENCER -- requirements
Module: gpio_apb_sequencer

Interface
REQ-001 SHALL have parameter GPIO_PINS, default 32, GPIO width, multiple of 8.
REQ-002 SHALL have parameter PADDR_SIZE, default 4, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum wait-state cycles per transfer.
REQ-004 SHALL have port pclk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port prstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins the configuration sequence.
REQ-007 SHALL have ports cfg_mode, cfg_dir, cfg_out, cfg_trig_type, cfg_trig_lvl0, cfg_trig_lvl1, cfg_irq_ena, input, GPIO_PINS each, register images.
REQ-008 SHALL have ports sw_req (in 1), sw_addr (in PADDR_SIZE), sw_wdata (in GPIO_PINS), sw_ack (out 1), forming a runtime write request port.
REQ-009 SHALL have APB master ports psel, penable, pwrite (out 1), paddr (out PADDR_SIZE), pwrdata (out GPIO_PINS), pstrb (out GPIO_PINS/8), and pready, pslverr (in 1), prddata (in GPIO_PINS).
REQ-010 SHALL have port irq_o, input, 1, level interrupt from the GPIO peripheral.
REQ-011 SHALL have ports cfg_done (out 1, level), err (out 1, sticky), irq_status (out GPIO_PINS), irq_valid (out 1, one-cycle pulse).

Function
REQ-012 SHALL use the register map MODE=0, DIRECTION=1, OUTPUT=2, TR_TYPE=4, TR_LVL0=5, TR_LVL1=6, TR_STATUS=7, IRQ_ENA=8.
REQ-013 SHALL implement states IDLE, SETUP, ACCESS, RUN, IRQ_RD, IRQ_CLR.
REQ-014 SHALL move IDLE->SETUP on start and issue the cfg writes in order MODE, DIRECTION, OUTPUT, TR_TYPE, TR_LVL0, TR_LVL1, IRQ_ENA, using a 3-bit index.
REQ-015 SHALL follow APB3 timing for each transfer: a SETUP cycle with psel=1 and penable=0, then ACCESS cycles with psel=1 and penable=1 until pready=1; paddr, pwrite and pwrdata SHALL be held stable from SETUP until completion.
REQ-016 SHALL drive pstrb all-ones for writes and all-zeros for reads.
REQ-017 SHALL, with no wait states, take exactly 2 cycles per transfer, giving 14 cycles from the first SETUP to cfg_done=1.
REQ-018 SHALL set cfg_done=1 after the 7th write completes, enter RUN, and hold cfg_done until reset.
REQ-019 SHALL ignore start when not in IDLE.
REQ-020 SHALL, in RUN with irq_o=1, read TR_STATUS (IRQ_RD), then write the read value back to TR_STATUS as write-1-to-clear (IRQ_CLR), then return to RUN.
REQ-021 SHALL update irq_status with prddata in the cycle pready=1 completes IRQ_RD, and pulse irq_valid that cycle.
REQ-022 SHALL, in RUN with sw_req=1 and irq_o=0, perform one write of sw_wdata to sw_addr and pulse sw_ack for one cycle on completion.
REQ-023 SHALL give irq_o priority over sw_req when both are asserted in the same RUN cycle; sw_req SHALL remain pending until acknowledged.
REQ-024 SHALL, on pslverr=1 at completion, set err=1, treat the transfer as complete and continue the sequence.
REQ-025 SHALL, if pready stays 0 for TIMEOUT ACCESS cycles, abort the transfer, set err=1, deassert psel and penable, and return to IDLE with cfg_done unchanged.
REQ-026 SHALL drive psel=0 and penable=0 in IDLE and RUN.

Reset
REQ-027 SHALL, on prstn=0 and regardless of pclk, enter IDLE and clear psel, penable, pwrite, paddr, pwrdata, pstrb, sw_ack, cfg_done, err, irq_status and irq_valid to 0.
REQ-028 SHALL, on reset mid-transfer, drop psel immediately; after release the sequence SHALL restart only on a new start.

Verification
REQ-029 Bench SHALL cover: start pulse, pready=1 always, cfg_dir=FFFFFFFF, cfg_out=00000088 -> writes to addresses 0,1,2,4,5,6,8 in order with the given data, and cfg_done=1 14 cycles after the first SETUP.
REQ-030 Bench SHALL cover: pready held low for 2 cycles on the DIRECTION write -> ACCESS extends 2 cycles with paddr=1 stable, and no err.
REQ-031 Bench SHALL cover: irq_o=1 in RUN with prddata=00000010 -> read of address 7, irq_status=00000010 with irq_valid pulse, then a write of 00000010 to address 7.
REQ-032 Bench SHALL cover: sw_req and irq_o asserted in the same cycle with sw_addr=2 and sw_wdata=000000FF -> IRQ read/clear first, then the write to address 2, then sw_ack.
REQ-033 Bench SHALL cover: pready=0 indefinitely -> after 15 ACCESS cycles err=1, psel=0 and state IDLE; and pslverr=1 on the MODE write -> err=1 while the sequence still completes.
REQ-034 Bench SHALL cover: prstn asserted during the OUTPUT write -> all outputs 0 asynchronously, and no transfer until the next start.
